// File: rtl/down_count_ctrl_pkg.sv
// Shared types and constants for the down-count controller and its datapath.
package down_count_ctrl_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int STEP_ONE  = 1;
  localparam int STEP_TWO  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/down_count_ctrl_datapath.sv
// Loadable down-counter register with a selectable step and a zero flag.
module dcnt_datapath
  import down_count_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Load wins over decrement so the controller can clear or reload in one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= count - step;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/down_count_ctrl.sv
// IDLE/RUN sequencer for a loadable down-counter: start, pause, abort, auto-reload.
module down_count_ctrl
  import down_count_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step_sel,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output state_t           state_dbg
);

  // Handshake: start is a level sampled only in IDLE; while busy=1 it is ignored
  // and the requester must hold or re-issue it once busy drops.

  state_t           state, next_state;
  logic [WIDTH-1:0] cap_load;
  logic             cap_step;
  logic             cap_reload;

  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             dec_en;
  logic             capture;
  logic             done_set;
  logic             err_set;
  logic             err_clr;
  logic             zero;
  logic [WIDTH-1:0] step;

  wire bad_cfg = step_sel & load_val[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start && !bad_cfg) next_state = ST_RUN;
      ST_RUN: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (!pause && zero && !cap_reload) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    load_en   = 1'b0;
    load_data = '0;
    dec_en    = 1'b0;
    capture   = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (bad_cfg) begin
            err_set = 1'b1;
          end else begin
            capture   = 1'b1;
            load_en   = 1'b1;
            load_data = load_val;
            err_clr   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Pause also defers the terminal check, so a paused zero never pulses done.
        if (abort) begin
          load_en = 1'b1;
        end else if (!pause) begin
          if (zero) begin
            done_set = 1'b1;
            if (cap_reload) begin
              load_en   = 1'b1;
              load_data = cap_load;
            end
          end else begin
            dec_en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_load   <= '0;
      cap_step   <= 1'b0;
      cap_reload <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (capture) begin
        cap_load   <= load_val;
        cap_step   <= step_sel;
        cap_reload <= auto_reload;
      end
      done <= done_set;
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  assign step      = cap_step ? WIDTH'(STEP_TWO) : WIDTH'(STEP_ONE);
  assign busy      = (state == ST_RUN);
  assign state_dbg = state;

  dcnt_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load_en),
    .load_value (load_data),
    .en         (dec_en),
    .step       (step),
    .count      (count),
    .zero       (zero)
  );

endmodule

// File: tb/tb_down_count_ctrl.sv
// Directed and randomized checks of down_count_ctrl against a rule-level model.
module tb_down_count_ctrl;
  import down_count_ctrl_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] load_val;
  logic         step_sel;
  logic         auto_reload;
  logic         pause;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         err;
  state_t       state_dbg;

  int checks   = 0;
  int failures = 0;

  // Reference model state: plain integers, updated once per clock edge.
  bit m_run;
  int m_count;
  bit m_done;
  bit m_err;
  int m_load;
  int m_step;
  bit m_reload;
  int done_seen;

  down_count_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .load_val    (load_val),
    .step_sel    (step_sel),
    .auto_reload (auto_reload),
    .pause       (pause),
    .abort       (abort),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .state_dbg   (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_count = 0; m_done = 0; m_err = 0;
    m_load = 0; m_step = 1; m_reload = 0;
  endtask

  task automatic model_edge();
    bit nd;
    nd = 0;
    if (!m_run) begin
      if (start) begin
        if (step_sel && (load_val % 2 == 1)) begin
          m_err = 1;
        end else begin
          m_load = load_val; m_step = step_sel ? 2 : 1; m_reload = auto_reload;
          m_count = load_val; m_err = 0; m_run = 1;
        end
      end
    end else if (abort) begin
      m_count = 0; m_run = 0;
    end else if (pause) begin
      // hold
    end else if (m_count == 0) begin
      nd = 1;
      if (m_reload) m_count = m_load;
      else m_run = 0;
    end else begin
      m_count = m_count - m_step;
    end
    m_done = nd;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(m_count));
    chk({tag, "_busy"}, 32'(busy), 32'(m_run));
    chk({tag, "_done"}, 32'(done), 32'(m_done));
    chk({tag, "_err"}, 32'(err), 32'(m_err));
    chk({tag, "_state"}, 32'(state_dbg), 32'(m_run ? ST_RUN : ST_IDLE));
  endtask

  task automatic drive(input bit s, input int lv, input bit ss, input bit ar, input bit p, input bit a);
    start = s; load_val = W'(lv); step_sel = ss; auto_reload = ar; pause = p; abort = a;
  endtask

  // One clock edge: model advances from pre-edge inputs, DUT sampled 1 time unit later.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    if (done === 1'b1) done_seen++;
    compare_model(tag);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("reset_count", 32'(count), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_err", 32'(err), 0);
    rst = 1'b1;

    // Even mode, load 6: 6,4,2,0 then done with busy falling.
    drive(1, 6, 1, 0, 0, 0); tick("t1_start");
    chk("t1_c6", 32'(count), 6);
    drive(0, 6, 1, 0, 0, 0);
    tick("t1"); chk("t1_c4", 32'(count), 4);
    tick("t1"); chk("t1_c2", 32'(count), 2);
    tick("t1"); chk("t1_c0", 32'(count), 0);
    chk("t1_busy_at0", 32'(busy), 1);
    tick("t1_term"); chk("t1_done", 32'(done), 1); chk("t1_idle", 32'(busy), 0);
    tick("t1_after"); chk("t1_done_gone", 32'(done), 0);

    // Odd load in even mode is rejected; a good start clears err.
    drive(1, 5, 1, 0, 0, 0); tick("t2_bad");
    chk("t2_err", 32'(err), 1); chk("t2_busy", 32'(busy), 0); chk("t2_cnt", 32'(count), 0);
    drive(1, 3, 0, 0, 0, 0); tick("t2_good");
    chk("t2_err_clr", 32'(err), 0); chk("t2_c3", 32'(count), 3);
    drive(0, 0, 0, 0, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 4; i++) tick("t2_run");
    chk("t2_done_once", 32'(done_seen), 1);

    // Pause holds count for three cycles at 4.
    drive(1, 8, 1, 0, 0, 0); tick("t3_start");
    drive(0, 0, 0, 0, 0, 0); tick("t3"); tick("t3");
    chk("t3_c4", 32'(count), 4);
    drive(0, 0, 0, 0, 1, 0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick("t3_pause"); chk("t3_hold", 32'(count), 4);
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick("t3_run");
    chk("t3_done_once", 32'(done_seen), 1);

    // Auto-reload: 4,2,0,4,... then abort with pause on the same edge.
    drive(1, 4, 1, 1, 0, 0); tick("t4_start");
    drive(0, 0, 0, 0, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) tick("t4_run");
    chk("t4_reloads", 32'(done_seen), 2);
    chk("t4_busy", 32'(busy), 1);
    drive(0, 0, 0, 0, 1, 1); tick("t4_abort");
    chk("t4_ab_cnt", 32'(count), 0); chk("t4_ab_busy", 32'(busy), 0); chk("t4_ab_done", 32'(done), 0);
    drive(0, 0, 0, 0, 0, 0); tick("t4_idle");

    // Start during a run is ignored; then asynchronous reset between edges.
    drive(1, 10, 0, 0, 0, 0); tick("t5_start");
    drive(0, 0, 0, 0, 0, 0); tick("t5"); tick("t5");
    drive(1, 3, 1, 1, 0, 0); tick("t5_restart");
    chk("t5_ignored", 32'(count), 7);
    drive(0, 0, 0, 0, 0, 0); tick("t5");
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("t5_rst_cnt", 32'(count), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_done", 32'(done), 0);
    #1 rst = 1'b1;

    // Load 0: busy for exactly one cycle, done on the next.
    drive(1, 0, 1, 0, 0, 0); tick("t6_start");
    chk("t6_busy", 32'(busy), 1);
    drive(0, 0, 0, 0, 0, 0); tick("t6_term");
    chk("t6_done", 32'(done), 1); chk("t6_idle", 32'(busy), 0);
    tick("t6_after");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int lv;
      bit ss;
      lv = $urandom_range(0, (1 << W) - 1);
      ss = 1'($urandom_range(0, 1));
      if (ss && $urandom_range(0, 3) != 0) lv = lv & ~1;
      drive($urandom_range(0, 2) == 0, lv, ss, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
